// File: rtl/mmm_serial_datapath.sv
// Bit-serial Montgomery multiplier datapath: result = A*B*2^-(WIDTH+2) mod M, kept below 2M.
// One multiplier bit is consumed per enabled cycle; the engine stops by itself after WIDTH+2 steps.
module mmm_serial_datapath #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic             ena,
   input  logic             rst_mmm,
   input  logic             ld_a,
   input  logic [WIDTH+1:0] a_in,
   input  logic [WIDTH+1:0] b_in,
   input  logic [WIDTH-1:0] m_in,
   input  logic             ld_r,
   output logic [WIDTH+1:0] result,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH + 3);
   localparam logic [CW-1:0] LAST = CW'(WIDTH + 2);

   logic [WIDTH+1:0] a_reg, b_reg, acc_reg, result_reg;
   logic [WIDTH-1:0] m_reg;
   logic [CW-1:0]    count_reg;
   logic             loaded_reg;

   logic [WIDTH+2:0] s1, s2;
   logic [WIDTH+1:0] acc_next;
   logic             running;

   // One extra bit of headroom: with A, B < 2M every partial sum stays below 2^(WIDTH+3).
   always_comb begin
      s1       = {1'b0, acc_reg} + (a_reg[0] ? {1'b0, b_reg} : '0);
      s2       = s1 + (s1[0] ? {3'b000, m_reg} : '0);
      acc_next = s2[WIDTH+2:1];
      running  = (count_reg < LAST);
   end

   always_ff @(posedge clk) begin
      if (!rstb) begin
         a_reg      <= '0;
         b_reg      <= '0;
         m_reg      <= '0;
         acc_reg    <= '0;
         count_reg  <= '0;
         result_reg <= '0;
         loaded_reg <= 1'b0;
      end else if (ena) begin
         if (!rst_mmm) begin
            acc_reg    <= '0;
            a_reg      <= '0;
            count_reg  <= '0;
            loaded_reg <= 1'b0;
         end else if (ld_a) begin
            a_reg      <= a_in;
            b_reg      <= b_in;
            m_reg      <= m_in;
            acc_reg    <= '0;
            count_reg  <= '0;
            loaded_reg <= 1'b1;
         end else if (running) begin
            acc_reg   <= acc_next;
            a_reg     <= a_reg >> 1;
            count_reg <= count_reg + CW'(1);
         end
         // Captures the accumulator as it was before this edge's update.
         if (ld_r) begin
            result_reg <= acc_reg;
         end
      end
   end

   // Gated by the loaded flag so the engine reads idle until operands arrive.
   assign busy   = rst_mmm & running & loaded_reg;
   assign done   = loaded_reg & (count_reg == LAST);
   assign result = result_reg;

endmodule
